dual_pwm_gen: RTL and testbench
===============================

// Module: dual_pwm_gen
// PURPOSE
//  Two-channel PWM generator and the consuming end of the X/Y duty-cycle interface.
//  The button-driven position block supplies two 6-bit duty words.
//  This block turns them into two PWM waveforms that drive the pan/tilt actuators.
//  Duty words are sampled into shadow registers only at a period boundary, so a
//  mid-period change never produces a glitched or truncated pulse.
// PARAMETERS
//  DUTY_W   6   width of duty inputs; one period = 2**DUTY_W ticks
//  CLK_DIV  4   clk cycles per PWM tick (>=1); period = CLK_DIV * 2**DUTY_W clk cycles
// PORTS
//  clk           in   1        system clock, all logic on rising edge
//  reset         in   1        reset, synchronous, active-high
//  enable        in   1        1 = run; 0 = outputs low, counters held at 0
//  duty_x        in   DUTY_W   requested X duty, in ticks high per period
//  duty_y        in   DUTY_W   requested Y duty, in ticks high per period
//  pwm_x         out  1        X PWM output, registered
//  pwm_y         out  1        Y PWM output, registered
//  period_start  out  1        1-clk pulse in the cycle the shadow duties load (tick 0)
//  duty_x_act    out  DUTY_W   X duty currently in effect (shadow register)
//  duty_y_act    out  DUTY_W   Y duty currently in effect (shadow register)
// BEHAVIOUR
//  - Reset, synchronous: pwm_x/y = 0, period_start = 0, duty_*_act = 0.
//    The prescaler and tick counter clear.
//    The first period starts on the first enabled cycle after reset is released.
//  - Prescaler: counts 0..CLK_DIV-1 while enable=1. On wrap it produces a tick strobe.
//    With CLK_DIV = 1 the tick strobe is high every cycle.
//  - Tick counter: DUTY_W bits. Increments on each tick strobe and wraps 2**DUTY_W-1 -> 0.
//    Wrap is natural modulo; there is no terminal compare.
//  - Period start occurs when the tick counter is 0 and the prescaler is 0 (first clk of tick 0).
//    In that cycle: duty_*_act <= duty_*, and period_start = 1.
//  - Inputs are sampled only at period start. All other cycles ignore duty_x/duty_y.
//  - Output rule, per channel: pwm <= (tick_cnt < duty_act), evaluated with the newly loaded shadow.
//    Consequences:
//    - duty 0 gives a constant low.
//    - duty 2**DUTY_W-1 gives exactly 1 low tick per period.
//    - A 100% high level is not reachable.
//  - Latency: output is registered, so pwm lags the counter state by 1 clk.
//    A duty change is seen in the output at the next period start + 1 clk; worst case 1 period + 1 clk.
//  - enable=0: synchronous clear of the prescaler, tick counter, pwm_x/y and period_start.
//    duty_*_act holds its value.
//    When enable returns to 1, that cycle is a period start: fresh load, full period.
//  - reset mid-period: the pulse is cut immediately (output low the next clk). No partial period is resumed.
//  - Simultaneous reset and enable: reset wins.
//  - Both channels share the prescaler and tick counter, so their rising edges are aligned at tick 0.
// STRUCTURE
//  - Package pwm_pkg: DUTY_W default, localparam PERIOD_TICKS = 2**DUTY_W, typedef duty_t = logic[DUTY_W-1:0].
//  - Top level holds the shared prescaler, tick counter and period_start generation.
//  - Sub-module pwm_channel (instantiated twice): shadow register plus compare plus output flop.
//    Ports: clk, reset, enable, load, tick_cnt, duty_in, pwm, duty_act.
// TESTING  (DUTY_W=6, CLK_DIV=4 -> period 256 clk)
//  1. Assert reset for 3 clk with duty_x=20 -> pwm_x=pwm_y=0, duty_*_act=0, period_start=0.
//  2. enable=1, duty_x=16, duty_y=48 -> per 256-clk period: pwm_x high 64 clk, pwm_y high 192 clk.
//     Rising edges coincide; period_start pulses every 256 clk.
//  3. Change duty_x from 16 to 48 at tick 30 -> current period keeps 64 clk high.
//     The next period has 192 clk high; duty_x_act changes only on period_start.
//  4. duty_x=0 -> pwm_x never rises over 3 periods.
//     duty_x=63 -> pwm_x low exactly 4 clk per period, at ticks 63.
//  5. Assert reset for 1 clk at tick 10 with duty 32 -> pwm low the next clk.
//     Period restarts at tick 0 after release; next high width is 128 clk.
//  6. Drop enable at tick 40, hold 100 clk, raise it -> outputs low while disabled.
//     period_start asserts on the re-enable cycle, then a full 256-clk period follows.
//     Also run the CLK_DIV=1 variant: period is 64 clk.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the pan/tilt PWM generator.
// The duty width here is the system default. The top level can override it.
package pwm_pkg;

  localparam int DUTY_W_DEFAULT  = 6;
  localparam int CLK_DIV_DEFAULT = 4;
  localparam int PERIOD_TICKS    = 2 ** DUTY_W_DEFAULT;

  typedef logic [DUTY_W_DEFAULT-1:0] duty_t;

  // Prescaler width. A divider of 1 still needs a one-bit counter.
  function automatic int presc_width(input int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel. It holds a shadow duty register that loads at period start,
// compares that duty against the shared tick counter, and drives a registered output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [DUTY_W-1:0] tick_cnt,
  input  logic [DUTY_W-1:0] duty_in,
  output logic              pwm,
  output logic [DUTY_W-1:0] duty_act
);

  logic [DUTY_W-1:0] duty_act_q, duty_act_d;
  logic              pwm_q, pwm_d;

  // NOTE: every signal driven in always_comb gets a default on its first line.
  // Without that default, a missed branch would infer a latch.
  always_comb begin
    duty_act_d = duty_act_q;
    pwm_d      = 1'b0;
    if (load) begin
      duty_act_d = duty_in;
    end
    // The compare uses the freshly loaded shadow, so tick 0 of a new period already
    // reflects the new duty.
    if (enable) begin
      pwm_d = (tick_cnt < duty_act_d);
    end
  end

  // NOTE: reset is synchronous and sits inside the clocked block. State updates use
  // non-blocking assignments so all flops sample the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm      = pwm_q;
  assign duty_act = duty_act_q;

endmodule

// File: rtl/dual_pwm_gen.sv
// Two-channel PWM generator for the pan/tilt actuators.
// One prescaler and one tick counter are shared, so both channels rise together at tick 0.
module dual_pwm_gen
  import pwm_pkg::*;
#(
  parameter int DUTY_W  = DUTY_W_DEFAULT,
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty_x,
  input  logic [DUTY_W-1:0] duty_y,
  output logic              pwm_x,
  output logic              pwm_y,
  output logic              period_start,
  output logic [DUTY_W-1:0] duty_x_act,
  output logic [DUTY_W-1:0] duty_y_act
);

  localparam int               PRE_W    = presc_width(CLK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [DUTY_W-1:0] tick_q, tick_d;
  logic              period_start_q, period_start_d;
  logic              tick_stb;
  logic              load;

  always_comb begin
    presc_d        = presc_q;
    tick_d         = tick_q;
    tick_stb       = (presc_q == PRE_LAST);
    // Period start is the first clk of tick 0. Re-enabling lands here because
    // disable clears both counters.
    load           = enable && (presc_q == '0) && (tick_q == '0);
    period_start_d = load;
    if (!enable) begin
      presc_d = '0;
      tick_d  = '0;
    end else begin
      presc_d = tick_stb ? '0 : presc_q + PRE_W'(1);
      if (tick_stb) begin
        tick_d = tick_q + DUTY_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q        <= '0;
      tick_q         <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      tick_q         <= tick_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  pwm_channel #(.DUTY_W(DUTY_W)) u_chan_x (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .tick_cnt (tick_q),
    .duty_in  (duty_x),
    .pwm      (pwm_x),
    .duty_act (duty_x_act)
  );

  pwm_channel #(.DUTY_W(DUTY_W)) u_chan_y (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .tick_cnt (tick_q),
    .duty_in  (duty_y),
    .pwm      (pwm_y),
    .duty_act (duty_y_act)
  );

endmodule

// File: tb/tb_dual_pwm_gen.sv
// Bench for dual_pwm_gen. It drives a CLK_DIV=4 instance and a CLK_DIV=1 instance with the
// same inputs and compares both against a period-phase reference model every clk.
module tb_dual_pwm_gen;
  import pwm_pkg::*;

  logic  clk;
  logic  reset;
  logic  enable;
  duty_t duty_x;
  duty_t duty_y;

  logic  pwm_x4, pwm_y4, ps4;
  duty_t ax4, ay4;
  logic  pwm_x1, pwm_y1, ps1;
  duty_t ax1, ay1;

  int vectors;
  int miscompares;

  // Reference model state, indexed 0 = CLK_DIV 4, 1 = CLK_DIV 1.
  // It tracks the clk count since the current period began.
  int    m_phase[2];
  duty_t m_ax[2];
  duty_t m_ay[2];
  logic  m_px[2];
  logic  m_py[2];
  logic  m_ps[2];

  dual_pwm_gen #(.DUTY_W(6), .CLK_DIV(4)) u_dut_div4 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .duty_x       (duty_x),
    .duty_y       (duty_y),
    .pwm_x        (pwm_x4),
    .pwm_y        (pwm_y4),
    .period_start (ps4),
    .duty_x_act   (ax4),
    .duty_y_act   (ay4)
  );

  dual_pwm_gen #(.DUTY_W(6), .CLK_DIV(1)) u_dut_div1 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .duty_x       (duty_x),
    .duty_y       (duty_y),
    .pwm_x        (pwm_x1),
    .pwm_y        (pwm_y1),
    .period_start (ps1),
    .duty_x_act   (ax1),
    .duty_y_act   (ay1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int div_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Updates the model for one rising edge with the given inputs.
  task automatic model_step(input logic r, input logic e, input duty_t dx, input duty_t dy);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_phase[d] = 0;
        m_ax[d] = '0;
        m_ay[d] = '0;
        m_px[d] = 1'b0;
        m_py[d] = 1'b0;
        m_ps[d] = 1'b0;
      end else if (!e) begin
        m_phase[d] = 0;
        m_px[d] = 1'b0;
        m_py[d] = 1'b0;
        m_ps[d] = 1'b0;
      end else begin
        int tick;
        m_ps[d] = (m_phase[d] == 0);
        if (m_ps[d]) begin
          m_ax[d] = dx;
          m_ay[d] = dy;
        end
        tick = m_phase[d] / div_of(d);
        m_px[d] = (tick < int'(m_ax[d]));
        m_py[d] = (tick < int'(m_ay[d]));
        m_phase[d] = (m_phase[d] + 1) % (div_of(d) * PERIOD_TICKS);
      end
    end
  endtask

  // Applies one clk of stimulus and checks every output of both instances.
  task automatic cycle(input logic r, input logic e, input duty_t dx, input duty_t dy);
    reset  = r;
    enable = e;
    duty_x = dx;
    duty_y = dy;
    @(posedge clk);
    model_step(r, e, dx, dy);
    #1;
    chk("div4 pwm_x",        {31'b0, pwm_x4}, {31'b0, m_px[0]});
    chk("div4 pwm_y",        {31'b0, pwm_y4}, {31'b0, m_py[0]});
    chk("div4 period_start", {31'b0, ps4},    {31'b0, m_ps[0]});
    chk("div4 duty_x_act",   {26'b0, ax4},    {26'b0, m_ax[0]});
    chk("div4 duty_y_act",   {26'b0, ay4},    {26'b0, m_ay[0]});
    chk("div1 pwm_x",        {31'b0, pwm_x1}, {31'b0, m_px[1]});
    chk("div1 pwm_y",        {31'b0, pwm_y1}, {31'b0, m_py[1]});
    chk("div1 period_start", {31'b0, ps1},    {31'b0, m_ps[1]});
    chk("div1 duty_x_act",   {26'b0, ax1},    {26'b0, m_ax[1]});
    chk("div1 duty_y_act",   {26'b0, ay1},    {26'b0, m_ay[1]});
  endtask

  // Runs one 256-clk window from a period start and counts high clks per output.
  // The X duty switches to dx_new from clk index chg_at onward.
  task automatic measure(input duty_t dx, input duty_t dy, input int chg_at, input duty_t dx_new,
                         output int hx, output int hy, output int nps4,
                         output int hx1, output int nps1);
    hx = 0; hy = 0; nps4 = 0; hx1 = 0; nps1 = 0;
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, 1'b1, (chg_at >= 0 && i >= chg_at) ? dx_new : dx, dy);
      hx   += int'(pwm_x4);
      hy   += int'(pwm_y4);
      nps4 += int'(ps4);
      hx1  += int'(pwm_x1);
      nps1 += int'(ps1);
    end
  endtask

  initial begin
    int hx, hy, nps4, hx1, nps1;
    duty_t rdx, rdy;
    vectors     = 0;
    miscompares = 0;
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_ax[d] = '0; m_ay[d] = '0;
      m_px[d] = 1'b0; m_py[d] = 1'b0; m_ps[d] = 1'b0;
    end
    reset = 1'b1; enable = 1'b1; duty_x = 6'd20; duty_y = 6'd20;

    // Reset with enable high: reset wins and every output stays zero.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 6'd20, 6'd20);
    chk("reset pwm_x", {31'b0, pwm_x4}, 32'd0);
    chk("reset duty_x_act", {26'b0, ax4}, 32'd0);

    // Steady run. 16/48 ticks give 64/192 clks high. CLK_DIV 1 runs 4 periods in the same window.
    measure(6'd16, 6'd48, -1, 6'd0, hx, hy, nps4, hx1, nps1);
    chk("steady x high clks", hx, 32'd64);
    chk("steady y high clks", hy, 32'd192);
    chk("steady period starts", nps4, 32'd1);
    chk("div1 x high clks", hx1, 32'd64);
    chk("div1 period starts", nps1, 32'd4);

    // Mid-period duty change at tick 30 takes effect only at the next period.
    measure(6'd16, 6'd48, 120, 6'd48, hx, hy, nps4, hx1, nps1);
    chk("midchange old width", hx, 32'd64);
    measure(6'd48, 6'd48, -1, 6'd0, hx, hy, nps4, hx1, nps1);
    chk("midchange new width", hx, 32'd192);

    // Duty 0 is constant low. Duty 63 is low for exactly one tick.
    for (int p = 0; p < 3; p++) begin
      measure(6'd0, 6'd48, -1, 6'd0, hx, hy, nps4, hx1, nps1);
      chk("duty0 high clks", hx, 32'd0);
    end
    measure(6'd63, 6'd63, -1, 6'd0, hx, hy, nps4, hx1, nps1);
    chk("duty63 low clks", 256 - hx, 32'd4);

    // Reset at tick 10 cuts the pulse. The next period is a full 128-clk pulse.
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 6'd32, 6'd32);
    cycle(1'b1, 1'b0, 6'd32, 6'd32);
    chk("reset cut pwm_x", {31'b0, pwm_x4}, 32'd0);
    measure(6'd32, 6'd32, -1, 6'd0, hx, hy, nps4, hx1, nps1);
    chk("post-reset width", hx, 32'd128);

    // Disable at tick 40 for 100 clks, then re-enable to start a full period.
    for (int i = 0; i < 160; i++) cycle(1'b0, 1'b1, 6'd32, 6'd10);
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, 6'd32, 6'd10);
    chk("disabled pwm_x", {31'b0, pwm_x4}, 32'd0);
    chk("disabled duty hold", {26'b0, ax4}, 32'd32);
    measure(6'd20, 6'd10, -1, 6'd0, hx, hy, nps4, hx1, nps1);
    chk("reenable x width", hx, 32'd80);
    chk("reenable y width", hy, 32'd40);
    chk("reenable period starts", nps4, 32'd1);

    // Randomized run with occasional disable and reset pulses.
    rdx = 6'($urandom);
    rdy = 6'($urandom);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) rdx = 6'($urandom);
      if ($urandom_range(0, 39) == 0) rdy = 6'($urandom);
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) != 0), rdx, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
